// File: rtl/md_sched.sv
// Multiply/divide scheduler for the MIPS core: owns HI/LO and raises busy while an op is in flight.
// Define MD_SCHED_MADD_EN to add madd/maddu accumulation into {hi,lo}.
module md_sched #(
    parameter int unsigned MUL_LAT = 5,
    parameter int unsigned DIV_LAT = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [3:0]  op,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int unsigned MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int unsigned CNT_W   = $clog2(MAX_LAT + 1);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;
`ifdef MD_SCHED_MADD_EN
    localparam logic [3:0] OP_MADD  = 4'd7;
    localparam logic [3:0] OP_MADDU = 4'd8;
`endif

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [31:0]       a_q;
    logic [31:0]       b_q;
    logic [3:0]        op_q;

    logic              is_mul;
    logic              is_div;
    logic [63:0]       prod_s;
    logic [63:0]       prod_u;
    logic [31:0]       a_mag;
    logic [31:0]       b_mag;
    logic [31:0]       q_mag;
    logic [31:0]       r_mag;
    logic [31:0]       uq;
    logic [31:0]       ur;
    logic [63:0]       res;
    logic              res_we;

    // Decode of the incoming command into the two multi-cycle classes
    always_comb begin
        is_mul = (op == OP_MULT) || (op == OP_MULTU);
`ifdef MD_SCHED_MADD_EN
        is_mul = is_mul || (op == OP_MADD) || (op == OP_MADDU);
`endif
        is_div = (op == OP_DIV) || (op == OP_DIVU);
    end

    // Result of the latched operation; signed divide works on magnitudes so INT_MIN/-1 wraps cleanly
    always_comb begin
        prod_s = {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};
        prod_u = {32'd0, a_q} * {32'd0, b_q};
        a_mag  = a_q[31] ? (~a_q + 32'd1) : a_q;
        b_mag  = b_q[31] ? (~b_q + 32'd1) : b_q;
        q_mag  = 32'd0;
        r_mag  = 32'd0;
        uq     = 32'd0;
        ur     = 32'd0;
        if (b_q != 32'd0) begin
            q_mag = a_mag / b_mag;
            r_mag = a_mag % b_mag;
            uq    = a_q / b_q;
            ur    = a_q % b_q;
        end
        res    = {hi, lo};
        res_we = 1'b0;
        case (op_q)
            OP_MULT: begin
                res    = prod_s;
                res_we = 1'b1;
            end
            OP_MULTU: begin
                res    = prod_u;
                res_we = 1'b1;
            end
            OP_DIV: begin
                if (b_q != 32'd0) begin
                    res    = {(a_q[31] ? (~r_mag + 32'd1) : r_mag),
                              ((a_q[31] ^ b_q[31]) ? (~q_mag + 32'd1) : q_mag)};
                    res_we = 1'b1;
                end
            end
            OP_DIVU: begin
                if (b_q != 32'd0) begin
                    res    = {ur, uq};
                    res_we = 1'b1;
                end
            end
`ifdef MD_SCHED_MADD_EN
            OP_MADD: begin
                res    = {hi, lo} + prod_s;
                res_we = 1'b1;
            end
            OP_MADDU: begin
                res    = {hi, lo} + prod_u;
                res_we = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    // Scheduler FSM; commands arriving while RUN are dropped without touching any state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            a_q   <= '0;
            b_q   <= '0;
            op_q  <= '0;
            busy  <= 1'b0;
            hi    <= '0;
            lo    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        if (is_mul || is_div) begin
                            a_q   <= rs_data;
                            b_q   <= rt_data;
                            op_q  <= op;
                            cnt   <= is_mul ? CNT_W'(MUL_LAT) : CNT_W'(DIV_LAT);
                            state <= RUN;
                            busy  <= 1'b1;
                        end else if (op == OP_MTHI) begin
                            hi <= rs_data;
                        end else if (op == OP_MTLO) begin
                            lo <= rs_data;
                        end
                    end
                end
                RUN: begin
                    cnt <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        if (res_we) begin
                            hi <= res[63:32];
                            lo <= res[31:0];
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_md_sched.sv
// Directed bench for md_sched: reference model of HI/LO/busy checked every cycle plus literal expectations.
module tb_md_sched;

    localparam int unsigned MUL_LAT = 5;
    localparam int unsigned DIV_LAT = 10;

    localparam logic [3:0] OP_NOP   = 4'd0;
    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;
    localparam logic [3:0] OP_MADD  = 4'd7;
    localparam logic [3:0] OP_MADDU = 4'd8;
    localparam logic [3:0] OP_BAD   = 4'd15;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    logic [3:0]  op = 4'd0;
    logic [31:0] rs_data = 32'd0;
    logic [31:0] rt_data = 32'd0;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    int total = 0;
    int bad = 0;

    md_sched #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op),
        .rs_data(rs_data), .rt_data(rt_data),
        .busy(busy), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: an accepted long op finishes LAT edges later with its arithmetic result
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;
    logic        m_busy = 1'b0;
    int          cyc = 0;
    int          done_cyc = 0;
    logic [3:0]  m_op = 4'd0;
    logic [31:0] m_a = 32'd0;
    logic [31:0] m_b = 32'd0;

    function automatic int op_lat(input logic [3:0] o);
        case (o)
            OP_MULT, OP_MULTU: op_lat = MUL_LAT;
            OP_DIV, OP_DIVU:   op_lat = DIV_LAT;
`ifdef MD_SCHED_MADD_EN
            OP_MADD, OP_MADDU: op_lat = MUL_LAT;
`endif
            default:           op_lat = 0;
        endcase
    endfunction

    function automatic logic [64:0] model_calc(input logic [3:0] o, input logic [31:0] a,
                                               input logic [31:0] b, input logic [31:0] h,
                                               input logic [31:0] l);
        longint sa;
        longint sb;
        longint q;
        longint r;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        model_calc = {1'b0, h, l};
        case (o)
            OP_MULT: begin
                p = sa * sb;
                model_calc = {1'b1, p};
            end
            OP_MULTU: begin
                p = {32'd0, a} * {32'd0, b};
                model_calc = {1'b1, p};
            end
            OP_DIV: begin
                if (b != 32'd0) begin
                    q = sa / sb;
                    r = sa % sb;
                    model_calc = {1'b1, 32'(r), 32'(q)};
                end
            end
            OP_DIVU: begin
                if (b != 32'd0) model_calc = {1'b1, a % b, a / b};
            end
`ifdef MD_SCHED_MADD_EN
            OP_MADD: begin
                p = {h, l} + 64'(sa * sb);
                model_calc = {1'b1, p};
            end
            OP_MADDU: begin
                p = {h, l} + {32'd0, a} * {32'd0, b};
                model_calc = {1'b1, p};
            end
`endif
            default: ;
        endcase
    endfunction

    logic [64:0] m_res;
    assign m_res = model_calc(m_op, m_a, m_b, m_hi, m_lo);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_hi   <= 32'd0;
            m_lo   <= 32'd0;
            m_busy <= 1'b0;
            cyc    <= 0;
        end else begin
            cyc <= cyc + 1;
            if (m_busy) begin
                if (cyc == done_cyc) begin
                    m_busy <= 1'b0;
                    if (m_res[64]) begin
                        m_hi <= m_res[63:32];
                        m_lo <= m_res[31:0];
                    end
                end
            end else if (start) begin
                if (op == OP_MTHI) m_hi <= rs_data;
                else if (op == OP_MTLO) m_lo <= rs_data;
                else if (op_lat(op) != 0) begin
                    m_op     <= op;
                    m_a      <= rs_data;
                    m_b      <= rt_data;
                    done_cyc <= cyc + op_lat(op);
                    m_busy   <= 1'b1;
                end
            end
        end
    end

    always @(negedge clk) begin
        chk("busy_cyc", 32'(busy), 32'(m_busy));
        chk("hi_cyc", hi, m_hi);
        chk("lo_cyc", lo, m_lo);
    end

    // Present a command for exactly one edge; returns 1ns after that edge
    task automatic cmd(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
        start   = 1'b1;
        op      = o;
        rs_data = a;
        rt_data = b;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_idle(input int n0, output int n);
        n = n0;
        while (busy && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("busy_timeout", 32'(busy), 32'd0);
    endtask

    task automatic run_long(input string name, input logic [3:0] o, input logic [31:0] a,
                            input logic [31:0] b, input int lat,
                            input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        int n;
        cmd(o, a, b);
        wait_idle(0, n);
        chk({name, "_lat"}, 32'(n), 32'(lat));
        chk({name, "_hi"}, hi, exp_hi);
        chk({name, "_lo"}, lo, exp_lo);
    endtask

    initial begin
        int n;
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_hi", hi, 32'd0);
        chk("rst_lo", lo, 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        cmd(OP_MTHI, 32'h12345678, 32'd0);
        chk("mthi_hi", hi, 32'h12345678);
        chk("mthi_busy", 32'(busy), 32'd0);
        cmd(OP_MTLO, 32'h9ABCDEF0, 32'd0);
        chk("mtlo_lo", lo, 32'h9ABCDEF0);
        chk("mtlo_hi", hi, 32'h12345678);
        chk("mtlo_busy", 32'(busy), 32'd0);

        run_long("mult", OP_MULT, 32'd3, 32'hFFFFFFFE, MUL_LAT, 32'hFFFFFFFF, 32'hFFFFFFFA);
        run_long("multu", OP_MULTU, 32'd3, 32'hFFFFFFFE, MUL_LAT, 32'h00000002, 32'hFFFFFFFA);
        run_long("mult_nn", OP_MULT, 32'hFFFFFFF9, 32'hFFFFFFFD, MUL_LAT, 32'h0, 32'h15);
        run_long("multu_big", OP_MULTU, 32'hFFFFFFF9, 32'hFFFFFFFD, MUL_LAT, 32'hFFFFFFF6, 32'h15);
        run_long("div", OP_DIV, 32'd7, 32'hFFFFFFFE, DIV_LAT, 32'h1, 32'hFFFFFFFD);
        run_long("div_negdd", OP_DIV, 32'hFFFFFFF9, 32'd2, DIV_LAT, 32'hFFFFFFFF, 32'hFFFFFFFD);
        run_long("div_wrap", OP_DIV, 32'h80000000, 32'hFFFFFFFF, DIV_LAT, 32'h0, 32'h80000000);

        // divu with a stray start (mthi) during RUN that must be ignored
        cmd(OP_DIVU, 32'hFFFFFFFF, 32'd2);
        start = 1'b1;
        op = OP_MTHI;
        rs_data = 32'hDEADBEEF;
        @(posedge clk);
        #1;
        op = OP_MULT;
        rs_data = 32'd5;
        rt_data = 32'd5;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_idle(2, n);
        chk("divu_lat", 32'(n), 32'(DIV_LAT));
        chk("divu_hi", hi, 32'h1);
        chk("divu_lo", lo, 32'h7FFFFFFF);

        cmd(OP_MTHI, 32'h0000AAAA, 32'd0);
        cmd(OP_MTLO, 32'h00005555, 32'd0);
        run_long("div0", OP_DIV, 32'd5, 32'd0, DIV_LAT, 32'h0000AAAA, 32'h00005555);
        run_long("divu0", OP_DIVU, 32'd5, 32'd0, DIV_LAT, 32'h0000AAAA, 32'h00005555);

        // unknown ops (and madd/maddu when the feature is off) leave everything alone
        cmd(OP_NOP, 32'd1, 32'd1);
        chk("nop_busy", 32'(busy), 32'd0);
        cmd(OP_BAD, 32'd1, 32'd1);
        chk("bad_busy", 32'(busy), 32'd0);
        chk("bad_hi", hi, 32'h0000AAAA);

`ifdef MD_SCHED_MADD_EN
        cmd(OP_MTHI, 32'd0, 32'd0);
        cmd(OP_MTLO, 32'hFFFFFFFF, 32'd0);
        run_long("maddu", OP_MADDU, 32'd1, 32'd1, MUL_LAT, 32'h1, 32'h0);
        run_long("madd", OP_MADD, 32'hFFFFFFFF, 32'd1, MUL_LAT, 32'h0, 32'hFFFFFFFF);
`else
        cmd(OP_MADD, 32'd1, 32'd1);
        chk("madd_off_busy", 32'(busy), 32'd0);
        cmd(OP_MADDU, 32'd1, 32'd1);
        chk("maddu_off_busy", 32'(busy), 32'd0);
        chk("madd_off_lo", lo, 32'h00005555);
`endif

        // reset in the third busy cycle of a mult abandons it
        cmd(OP_MULT, 32'h1234, 32'h5678);
        repeat (2) @(posedge clk);
        #1;
        chk("pre_rst_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("midrst_hi", hi, 32'd0);
        chk("midrst_lo", lo, 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        chk("postrst_hi", hi, 32'd0);
        chk("postrst_lo", lo, 32'd0);
        run_long("post_mult", OP_MULT, 32'd2, 32'd3, MUL_LAT, 32'h0, 32'h6);

        repeat (2) @(posedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
